// File: rtl/decode_stage_p.sv
// RV32I decode stage: control/immediate decode, register file with optional
// write-back bypass, load-use bubble insertion and a decode/execute register.

module decode_stage_p_rdport #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int AW        = 5,
  parameter int BYPASS_WB = 1
) (
  input  logic [NREG-1:0][XLEN-1:0] regs,
  input  logic [AW-1:0]             raddr,
  input  logic                      wb_we,
  input  logic [AW-1:0]             wb_addr,
  input  logic [XLEN-1:0]           wb_data,
  output logic [XLEN-1:0]           rdata
);
  always_comb begin
    rdata = regs[raddr];
    if (BYPASS_WB != 0 && wb_we && wb_addr == raddr) rdata = wb_data;
    if (raddr == '0) rdata = '0;
  end
endmodule

module decode_stage_p #(
  parameter  int XLEN      = 32,
  parameter  int NREG      = 32,
  parameter  int BYPASS_WB = 1,
  parameter  int CNT_W     = 16,
  localparam int AW        = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus_4,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_pc_plus_4,
  output logic [AW-1:0]   ex_rd,
  output logic [18:0]     ex_ctrl,
  output logic            ex_illegal,
  output logic [CNT_W-1:0] bubble_cnt
);
  typedef struct packed {
    logic       mem_load;
    logic       b_src;
    logic       adr_adder_a;
    logic       is_branch;
    logic       rf_wb;
    logic       mem_we;
    logic [1:0] wb_src;
    logic       pc_src;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } ctrl_t;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_OPI   = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_MISC  = 7'b0001111;
  localparam logic [6:0] OPC_SYS   = 7'b1110011;

  logic [6:0] opc;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
  logic is_misc, is_sys, legal, uses_rs1, uses_rs2, hazard, load_en;
  ctrl_t dec_ctrl, ctrl_q;
  logic signed [31:0] imm32;
  logic [XLEN-1:0] dec_imm;
  logic [NREG-1:0][XLEN-1:0] regs;
  logic [1:0][AW-1:0]   rd_idx;
  logic [1:0][XLEN-1:0] rd_data;

  assign opc      = instr[6:0];
  assign is_lui   = opc == OPC_LUI;
  assign is_auipc = opc == OPC_AUIPC;
  assign is_jal   = opc == OPC_JAL;
  assign is_jalr  = opc == OPC_JALR;
  assign is_br    = opc == OPC_BR;
  assign is_ld    = opc == OPC_LD;
  assign is_st    = opc == OPC_ST;
  assign is_opi   = opc == OPC_OPI;
  assign is_op    = opc == OPC_OP;
  assign is_misc  = opc == OPC_MISC;
  assign is_sys   = opc == OPC_SYS;
  assign legal    = is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld |
                    is_st | is_opi | is_op | is_misc | is_sys;

  // Every enable is a pure OR of recognised opcodes, so an illegal opcode
  // already decodes to all enables low.
  always_comb begin
    dec_ctrl             = '0;
    dec_ctrl.mem_load    = is_ld;
    dec_ctrl.b_src       = is_opi | is_ld | is_st;
    dec_ctrl.adr_adder_a = is_br | is_jal;
    dec_ctrl.is_branch   = is_br;
    dec_ctrl.rf_wb       = is_op | is_opi | is_ld | is_jal | is_jalr;
    dec_ctrl.mem_we      = is_st;
    dec_ctrl.wb_src      = {is_ld, is_op | is_opi};
    dec_ctrl.pc_src      = is_br | is_jal | is_jalr | is_auipc | is_lui;
    dec_ctrl.funct3      = instr[14:12];
    dec_ctrl.funct7      = instr[31:25];
  end

  always_comb begin
    imm32 = '0;
    if (is_opi || is_ld || is_jalr || is_misc || is_sys)
      imm32 = 32'($signed(instr[31:20]));
    else if (is_st)
      imm32 = 32'($signed({instr[31:25], instr[11:7]}));
    else if (is_br)
      imm32 = 32'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    else if (is_lui || is_auipc)
      imm32 = {instr[31:12], 12'b0};
    else if (is_jal)
      imm32 = 32'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  end
  assign dec_imm = XLEN'(imm32);

  assign rd_idx[0] = is_lui ? '0 : instr[15 +: AW];
  assign rd_idx[1] = instr[20 +: AW];

  genvar p;
  generate
    for (p = 0; p < 2; p++) begin : g_rd
      decode_stage_p_rdport #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS_WB(BYPASS_WB)
      ) u_rd (
        .regs   (regs),
        .raddr  (rd_idx[p]),
        .wb_we  (wb_we),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .rdata  (rd_data[p])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs <= '0;
    else if (wb_we && wb_addr != '0) regs[wb_addr] <= wb_data;
  end

  assign uses_rs1 = is_op | is_opi | is_ld | is_st | is_br | is_jalr;
  assign uses_rs2 = is_op | is_st | is_br;
  assign hazard   = ex_valid & ctrl_q.mem_load & (ex_rd != '0) &
                    ((uses_rs1 & (rd_idx[0] == ex_rd)) | (uses_rs2 & (rd_idx[1] == ex_rd)));
  assign load_en  = ~ex_valid | ex_ready;
  assign if_ready = rst & (flush | (load_en & ~hazard));
  assign ex_ctrl  = ctrl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_pc        <= '0;
      ex_pc_plus_4 <= '0;
      ex_rd        <= '0;
      ctrl_q       <= '0;
      ex_illegal   <= 1'b0;
      bubble_cnt   <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (load_en) begin
      if (if_valid && !hazard) begin
        ex_valid     <= 1'b1;
        ex_rs1_data  <= rd_data[0];
        ex_rs2_data  <= rd_data[1];
        ex_imm       <= dec_imm;
        ex_pc        <= pc;
        ex_pc_plus_4 <= pc_plus_4;
        ex_rd        <= instr[7 +: AW];
        ctrl_q       <= dec_ctrl;
        ex_illegal   <= ~legal;
      end else begin
        ex_valid <= 1'b0;
      end
      if (hazard && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: decode table, load-use/stall/flush/bypass/reset
// sequences, then random traffic against a behavioural model.

module tb_decode_stage_p;
  localparam int XLEN = 32, NREG = 32, AW = 5, CW0 = 16, CW1 = 2;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic            if_valid, ex_ready, flush, wb_we;
  logic [31:0]     instr, pc, pc_plus_4, wb_data;
  logic [AW-1:0]   wb_addr;

  logic            o0_ifr, o0_v, o0_ill, o1_ifr, o1_v, o1_ill;
  logic [31:0]     o0_rs1, o0_rs2, o0_imm, o0_pc, o0_pc4;
  logic [31:0]     o1_rs1, o1_rs2, o1_imm, o1_pc, o1_pc4;
  logic [AW-1:0]   o0_rd, o1_rd;
  logic [18:0]     o0_ctrl, o1_ctrl;
  logic [CW0-1:0]  o0_cnt;
  logic [CW1-1:0]  o1_cnt;

  decode_stage_p #(.XLEN(XLEN), .NREG(NREG), .BYPASS_WB(1), .CNT_W(CW0)) u_dut0 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(o0_ifr), .instr(instr),
    .pc(pc), .pc_plus_4(pc_plus_4), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .ex_valid(o0_v), .ex_ready(ex_ready), .ex_rs1_data(o0_rs1),
    .ex_rs2_data(o0_rs2), .ex_imm(o0_imm), .ex_pc(o0_pc), .ex_pc_plus_4(o0_pc4),
    .ex_rd(o0_rd), .ex_ctrl(o0_ctrl), .ex_illegal(o0_ill), .bubble_cnt(o0_cnt));

  decode_stage_p #(.XLEN(XLEN), .NREG(NREG), .BYPASS_WB(0), .CNT_W(CW1)) u_dut1 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(o1_ifr), .instr(instr),
    .pc(pc), .pc_plus_4(pc_plus_4), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .ex_valid(o1_v), .ex_ready(ex_ready), .ex_rs1_data(o1_rs1),
    .ex_rs2_data(o1_rs2), .ex_imm(o1_imm), .ex_pc(o1_pc), .ex_pc_plus_4(o1_pc4),
    .ex_rd(o1_rd), .ex_ctrl(o1_ctrl), .ex_illegal(o1_ill), .bubble_cnt(o1_cnt));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic ml, bs, aa, br, wb, mw;
    logic [1:0] ws;
    logic ps, ill, u1, u2, lui;
    logic [31:0] imm;
  } dec_t;

  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t d;
    int ii, is, ib, iu, ij;
    d  = '0;
    ii = int'($signed(i[31:20]));
    is = int'($signed({i[31:25], i[11:7]}));
    ib = int'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    iu = int'({i[31:12], 12'h000});
    ij = int'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    case (i[6:0])
      7'h37: begin d.ps = 1; d.lui = 1; d.imm = iu; end
      7'h17: begin d.ps = 1; d.imm = iu; end
      7'h6F: begin d.aa = 1; d.wb = 1; d.ps = 1; d.imm = ij; end
      7'h67: begin d.wb = 1; d.ps = 1; d.u1 = 1; d.imm = ii; end
      7'h63: begin d.aa = 1; d.br = 1; d.ps = 1; d.u1 = 1; d.u2 = 1; d.imm = ib; end
      7'h03: begin d.ml = 1; d.bs = 1; d.wb = 1; d.ws = 2'b10; d.u1 = 1; d.imm = ii; end
      7'h23: begin d.bs = 1; d.mw = 1; d.u1 = 1; d.u2 = 1; d.imm = is; end
      7'h13: begin d.bs = 1; d.wb = 1; d.ws = 2'b01; d.u1 = 1; d.imm = ii; end
      7'h33: begin d.wb = 1; d.ws = 2'b01; d.u1 = 1; d.u2 = 1; end
      7'h0F, 7'h73: d.imm = ii;
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  logic [31:0] regs_m [NREG];
  logic        m_v, m_ill, m_ifr;
  logic [31:0] m_rs1, m_rs2, m_rs1b, m_rs2b, m_imm, m_pc, m_pc4;
  logic [4:0]  m_rd;
  logic [18:0] m_ctrl;
  int          m_cnt0, m_cnt1;
  logic        last_ifr;

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) regs_m[k] = '0;
    m_v = 0; m_ill = 0; m_rs1 = 0; m_rs2 = 0; m_rs1b = 0; m_rs2b = 0;
    m_imm = 0; m_pc = 0; m_pc4 = 0; m_rd = 0; m_ctrl = 0; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  function automatic logic [31:0] rdreg(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'd0;
    if (byp && wb_we && wb_addr == idx) return wb_data;
    return regs_m[idx];
  endfunction

  task automatic model_step();
    dec_t d;
    logic [4:0] r1, r2;
    bit haz, le;
    d   = ref_decode(instr);
    r1  = d.lui ? 5'd0 : instr[19:15];
    r2  = instr[24:20];
    haz = m_v && m_ctrl[18] && m_rd != 0 && ((d.u1 && r1 == m_rd) || (d.u2 && r2 == m_rd));
    le  = !m_v || ex_ready;
    m_ifr = flush || (le && !haz);
    if (flush) m_v = 0;
    else if (le) begin
      if (if_valid && !haz) begin
        m_v = 1;
        m_rs1 = rdreg(r1, 1); m_rs2 = rdreg(r2, 1);
        m_rs1b = rdreg(r1, 0); m_rs2b = rdreg(r2, 0);
        m_imm = d.imm; m_pc = pc; m_pc4 = pc_plus_4; m_rd = instr[11:7];
        m_ctrl = {d.ml, d.bs, d.aa, d.br, d.wb, d.mw, d.ws, d.ps, instr[14:12], instr[31:25]};
        m_ill = d.ill;
      end else m_v = 0;
      if (haz) begin
        if (m_cnt0 < 65535) m_cnt0++;
        if (m_cnt1 < 3) m_cnt1++;
      end
    end
    if (wb_we && wb_addr != 0) regs_m[wb_addr] = wb_data;
  endtask

  task automatic compare_all();
    chk("ex_valid", o0_v, m_v);
    chk("ex_rs1_data", o0_rs1, m_rs1);
    chk("ex_rs2_data", o0_rs2, m_rs2);
    chk("ex_imm", o0_imm, m_imm);
    chk("ex_pc", o0_pc, m_pc);
    chk("ex_pc_plus_4", o0_pc4, m_pc4);
    chk("ex_rd", o0_rd, m_rd);
    chk("ex_ctrl", o0_ctrl, m_ctrl);
    chk("ex_illegal", o0_ill, m_ill);
    chk("bubble_cnt", o0_cnt, m_cnt0);
    chk("nobyp_ex_valid", o1_v, m_v);
    chk("nobyp_rs1_data", o1_rs1, m_rs1b);
    chk("nobyp_rs2_data", o1_rs2, m_rs2b);
    chk("nobyp_ctrl", o1_ctrl, m_ctrl);
    chk("sat_bubble_cnt", o1_cnt, m_cnt1);
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic step();
    model_step();
    #2;
    last_ifr = o0_ifr;
    chk("if_ready", o0_ifr, m_ifr);
    chk("nobyp_if_ready", o1_ifr, m_ifr);
    @(posedge clk); #1;
    compare_all();
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [18:0] ctrl;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;
  vec_t vecs[10];

  localparam logic [6:0] OPS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                      7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 11) == 11) r[6:0] = 7'($urandom);
    else r[6:0] = OPS[$urandom_range(0, 10)];
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  initial begin
    vecs[0] = '{32'h00500093, 32'h00000005, 19'h24800, 5'd1,  1'b0}; // ADDI x1,x0,5
    vecs[1] = '{32'h123453B7, 32'h12345000, 19'h00689, 5'd7,  1'b0}; // LUI x7
    vecs[2] = '{32'h0020A423, 32'h00000008, 19'h22100, 5'd8,  1'b0}; // SW x2,8(x1)
    vecs[3] = '{32'hFE000EE3, 32'hFFFFFFFC, 19'h1847F, 5'd29, 1'b0}; // BEQ -4
    vecs[4] = '{32'h001000EF, 32'h00000800, 19'h14400, 5'd1,  1'b0}; // JAL x1,2048
    vecs[5] = '{32'hFFFFF197, 32'hFFFFF000, 19'h007FF, 5'd3,  1'b0}; // AUIPC x3
    vecs[6] = '{32'h001101B3, 32'h00000000, 19'h04800, 5'd3,  1'b0}; // ADD x3,x2,x1
    vecs[7] = '{32'h004280E7, 32'h00000004, 19'h04400, 5'd1,  1'b0}; // JALR x1,4(x5)
    vecs[8] = '{32'h0000007F, 32'h00000000, 19'h00000, 5'd0,  1'b1}; // illegal
    vecs[9] = '{32'hFFF0A103, 32'hFFFFFFFF, 19'h6517F, 5'd2,  1'b0}; // LW x2,-1(x1)

    if_valid = 1; ex_ready = 1; flush = 1; wb_we = 0; wb_addr = '0; wb_data = '0;
    instr = 32'h00500093; pc = 32'h100; pc_plus_4 = 32'h104;
    model_reset();
    @(posedge clk); #1;
    chk("rst_if_ready", o0_ifr, 1'b0);
    chk("rst_ex_valid", o0_v, 1'b0);
    chk("rst_bubble_cnt", o0_cnt, 0);
    chk("rst_ex_ctrl", o0_ctrl, 0);
    chk("rst_ex_imm", o0_imm, 0);
    compare_all();
    flush = 0; rst = 1;

    // decode table
    for (int i = 0; i < 10; i++) begin
      instr = vecs[i].instr; if_valid = 1; ex_ready = 1;
      pc = 32'h1000 + 32'(4 * i); pc_plus_4 = pc + 4;
      step();
      chk("tbl_if_ready", last_ifr, 1'b1);
      chk("tbl_ex_valid", o0_v, 1'b1);
      chk("tbl_ex_imm", o0_imm, vecs[i].imm);
      chk("tbl_ex_ctrl", o0_ctrl, vecs[i].ctrl);
      chk("tbl_ex_rd", o0_rd, vecs[i].rd);
      chk("tbl_ex_illegal", o0_ill, vecs[i].ill);
      chk("tbl_ex_pc", o0_pc, pc);
    end
    if_valid = 0; step();

    // load-use: LW x2,0(x1) then ADD x3,x2,x1
    instr = 32'h0000A103; if_valid = 1; step();
    chk("lu_load_valid", o0_v, 1'b1);
    instr = 32'h001101B3; step();
    chk("lu_if_ready_low", last_ifr, 1'b0);
    chk("lu_bubble_valid", o0_v, 1'b0);
    chk("lu_bubble_cnt", o0_cnt, 1);
    step();
    chk("lu_if_ready_back", last_ifr, 1'b1);
    chk("lu_add_issued", o0_v, 1'b1);
    chk("lu_add_rd", o0_rd, 3);

    // stall with ex_ready low for three cycles
    instr = 32'h001000EF; ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_if_ready", last_ifr, 1'b0);
      chk("stall_rd_hold", o0_rd, 3);
      chk("stall_valid_hold", o0_v, 1'b1);
    end
    ex_ready = 1; step();
    chk("stall_release_rd", o0_rd, 1);
    chk("stall_release_ctrl", o0_ctrl, 19'h14400);

    // flush drops the presented instruction
    flush = 1; instr = 32'h00500093; step();
    chk("flush_if_ready", last_ifr, 1'b1);
    chk("flush_valid", o0_v, 1'b0);
    chk("flush_bubble_cnt", o0_cnt, 1);
    flush = 0; if_valid = 0; step();
    chk("flush_dropped", o0_v, 1'b0);

    // same-cycle write-back: ADD x5,x4,x4
    wb_we = 1; wb_addr = 5'd4; wb_data = 32'hDEADBEEF; instr = 32'h004202B3; if_valid = 1;
    step();
    chk("byp_rs1", o0_rs1, 32'hDEADBEEF);
    chk("byp_rs2", o0_rs2, 32'hDEADBEEF);
    chk("nobyp_rs1_old", o1_rs1, 32'h0);
    chk("nobyp_rs2_old", o1_rs2, 32'h0);
    wb_we = 0; step();
    chk("nobyp_rs1_new", o1_rs1, 32'hDEADBEEF);

    // LUI ignores its rs1 field (x8 holds a nonzero value)
    wb_we = 1; wb_addr = 5'd8; wb_data = 32'h55; if_valid = 0; step();
    wb_we = 0; instr = 32'h123453B7; if_valid = 1; step();
    chk("lui_rs1_zero", o0_rs1, 32'h0);
    chk("lui_imm", o0_imm, 32'h12345000);
    chk("lui_pc_src", o0_ctrl[10], 1'b1);

    // asynchronous reset in the middle of a stall
    ex_ready = 0; step();
    #2 rst = 0;
    #1;
    chk("arst_valid", o0_v, 1'b0);
    chk("arst_bubble", o0_cnt, 0);
    chk("arst_if_ready", o0_ifr, 1'b0);
    @(posedge clk); #1;
    rst = 1; model_reset(); ex_ready = 1;
    instr = 32'h004202B3; step();
    chk("arst_regs_cleared", o0_rs1, 32'h0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if_valid  = ($urandom_range(0, 9) < 8);
      ex_ready  = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      wb_we     = $urandom_range(0, 1) == 1;
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      instr     = rnd_instr();
      pc        = $urandom;
      pc_plus_4 = pc + 4;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage_p.md
# decode_stage_p

Parametrised instruction-decode pipeline stage for the RV32I core, between fetch and execute. It decodes the instruction, reads operands from an internal register file with optional write-back bypass, and extends the immediate. Results go into a decode/execute pipeline register with a valid/ready handshake. It also detects load-use hazards, inserts bubbles, and counts those bubbles.

## Interface
- XLEN, 32: datapath width; ≥32; immediates sign-extended to XLEN.
- NREG, 32: register count, power of two ≤32; AW = clog2(NREG); register 0 hardwired to zero.
- BYPASS_WB, 1: 1 = same-cycle write-back data visible on operand reads; 0 = visible next cycle.
- CNT_W, 16: width of bubble counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_valid  in  1  fetch presents instruction.
- if_ready  out  1  stage accepts instruction this cycle.
- instr  in  32  instruction word.
- pc, pc_plus_4  in  XLEN  fetch PC and PC+4.
- wb_we  in  1  write-back enable.
- wb_addr  in  AW  write-back register index.
- wb_data  in  XLEN  write-back data.
- flush  in  1  synchronous kill of the stage contents.
- ex_valid  out  1  pipeline register holds a valid instruction.
- ex_ready  in  1  execute consumes pipeline register.
- ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_pc_plus_4  out  XLEN  registered operands, immediate, PCs.
- ex_rd  out  AW  destination index (instr[11:7], truncated to AW).
- ex_ctrl  out  19  {mem_load, b_src, adr_adder_a, is_branch, rf_wb, mem_we, wb_src[1:0], pc_src, funct3[2:0], funct7[6:0]}.
- ex_illegal  out  1  opcode not in RV32I base set.
- bubble_cnt  out  CNT_W  saturating count of hazard bubbles.

## Operation
- Control decode:
  - b_src = OP-IMM | LOAD | STORE.
  - adr_adder_a = BRANCH | JAL.
  - rf_wb = OP | OP-IMM | LOAD | JAL | JALR.
  - mem_we = STORE.
  - wb_src = {LOAD, OP|OP-IMM}.
  - pc_src = BRANCH | JAL | JALR | AUIPC | LUI.
  - For LUI, rs1 is forced to 0.
- Immediates: standard I/S/B/U/J formats selected by opcode; R-type gives 0.
- Register file:
  - NREG×XLEN, two combinational read ports, one write port.
  - Writes to index 0 are ignored; reads of index 0 return 0.
  - With BYPASS_WB=1, a read index equal to wb_addr with wb_we=1 and index≠0 returns wb_data.
- Register use:
  - uses_rs1 = OP|OP-IMM|LOAD|STORE|BRANCH|JALR.
  - uses_rs2 = OP|STORE|BRANCH.
- hazard = ex_valid & ex_ctrl.mem_load & ex_rd≠0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- Handshake:
  - load_en = ~ex_valid | ex_ready.
  - if_ready = flush | (load_en & ~hazard).
  - Transfer in = if_valid & if_ready & ~flush: the pipeline register captures the decoded fields and ex_valid←1.
  - load_en & ~flush with no transfer in: ex_valid←0, data fields hold.
  - When hazard & load_en, the bubble is inserted: ex_valid←0 and bubble_cnt increments, saturating at all-ones.
  - !load_en: all outputs hold (stall).
- Flush:
  - Highest priority: ex_valid←0 and any presented instruction is consumed and discarded.
  - bubble_cnt is unaffected.
- Illegal opcodes are passed through with ex_illegal=1 and all enables (rf_wb, mem_we, pc_src, is_branch) forced to 0.

## Timing
- Latency: transfer in at edge N gives ex_valid=1 with the fields after edge N.
- Throughput: one instruction per cycle with no hazard and ex_ready=1.
- A load-use pair costs exactly one bubble cycle:
  - The bubble replaces the load in the register.
  - The dependent instruction is accepted the next cycle, with EX/MEM forwarding external.
- Write-back:
  - Register write at edge N.
  - With BYPASS_WB=0, a read in the cycle before edge N returns old data.
- Reset (rst=0, asynchronous):
  - ex_valid=0, all ex_* data and ctrl = 0, ex_illegal=0, bubble_cnt=0, all registers=0.
  - if_ready=0 while in reset; it follows the equations from the first edge after release.
- Reset asserted mid-stall clears state immediately; no partial transfer.

## Test plan
- Reset then ADDI x1,x0,5 (0x00500093) with ex_ready=1 → next cycle ex_valid=1, ex_imm=5, ex_rd=1, rf_wb=1, b_src=1, wb_src=01.
- LW x2,0(x1) followed by ADD x3,x2,x1 → one cycle of if_ready=0 and ex_valid=0 after the LW, then ADD issues; bubble_cnt=1.
- wb_we=1, wb_addr=4, wb_data=0xDEADBEEF with ADD x5,x4,x4 decoded the same cycle → rs1/rs2 data 0xDEADBEEF for BYPASS_WB=1, old value (0) for BYPASS_WB=0.
- ex_ready=0 for 3 cycles with if_valid=1 → ex_* stable, if_ready=0, no instruction lost after ex_ready returns.
- flush=1 while the register holds a valid instruction and a new one is presented → ex_valid=0 next cycle, if_ready=1, new instruction dropped.
- LUI x7,0x12345 (0x123453B7) → ex_imm=0x12345000, ex_rs1_data=0, pc_src=1; opcode 0x7F → ex_illegal=1, rf_wb=0, mem_we=0.
